// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 target giving read/write access to a bank of
// configuration registers. Frame = R/W bit, address, data, all MSB first.
// Writes commit on chip-select release only when the frame length is exact.
module spi_regfile #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ncs,
  input  logic                         copi,
  input  logic                         sclk,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int          FRAME      = 1 + ADDR_W + DATA_W;
  localparam int          CNT_W      = $clog2(FRAME + 2);
  localparam logic [31:0] NUM_REGS_U = NUM_REGS;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  logic [SYNC_STAGES-1:0]      r_ncs_sync;
  logic [SYNC_STAGES-1:0]      r_sclk_sync;
  logic [SYNC_STAGES-1:0]      r_copi_sync;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [FRAME-1:0]            r_shift_in;
  logic [DATA_W-1:0]           r_out;
  logic                        r_cipo;
  logic                        r_cipo_oe;
  logic [NUM_REGS*DATA_W-1:0]  r_regs;
  logic                        r_wr_strobe;
  logic [ADDR_W-1:0]           r_wr_addr;
  logic                        r_frame_err;

  logic                        w_ncs_fall;
  logic                        w_ncs_rise;
  logic                        w_sclk_rise;
  logic                        w_sclk_fall;
  logic                        w_copi;
  logic [FRAME-1:0]            w_shift_nx;
  logic [CNT_W-1:0]            w_cnt_nx;
  logic [ADDR_W-1:0]           w_ld_addr;
  logic [DATA_W-1:0]           w_rd_data;
  logic [DATA_W-1:0]           w_out_sh;
  logic                        w_cmt_wr;
  logic [ADDR_W-1:0]           w_cmt_addr;
  logic [DATA_W-1:0]           w_cmt_data;
  logic                        w_addr_ok;

  // Input synchronisers; chip select idles high so reset cannot fake a select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncs_sync  <= {SYNC_STAGES{1'b1}};
      r_sclk_sync <= {SYNC_STAGES{1'b0}};
      r_copi_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
    end
  end

  // Edge detection on the last two synchroniser stages and frame field decode
  always_comb begin
    w_ncs_fall  = r_ncs_sync[SYNC_STAGES-1] & ~r_ncs_sync[SYNC_STAGES-2];
    w_ncs_rise  = ~r_ncs_sync[SYNC_STAGES-1] & r_ncs_sync[SYNC_STAGES-2];
    w_sclk_rise = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_sync[SYNC_STAGES-2];
    w_sclk_fall = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES-2];
    w_copi      = r_copi_sync[SYNC_STAGES-1];
    w_shift_nx  = {r_shift_in[FRAME-2:0], w_copi};
    w_cnt_nx    = (r_cnt == CNT_W'(FRAME + 1)) ? r_cnt : r_cnt + CNT_W'(1);
    w_ld_addr   = w_shift_nx[ADDR_W-1:0];
    w_out_sh    = {r_out[DATA_W-2:0], 1'b0};
    w_cmt_wr    = r_shift_in[FRAME-1];
    w_cmt_addr  = r_shift_in[DATA_W +: ADDR_W];
    w_cmt_data  = r_shift_in[DATA_W-1:0];
    w_addr_ok   = (32'(w_cmt_addr) < NUM_REGS_U);
  end

  // Read mux: unimplemented addresses read as zero
  always_comb begin
    w_rd_data = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      w_rd_data = w_rd_data |
                  ({DATA_W{w_ld_addr == ADDR_W'(k)}} & r_regs[k*DATA_W +: DATA_W]);
    end
  end

  // Frame FSM: bit counting, read-data shifting and commit on deselect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_shift_in  <= {FRAME{1'b0}};
      r_out       <= {DATA_W{1'b0}};
      r_cipo      <= 1'b0;
      r_cipo_oe   <= 1'b0;
      r_regs      <= {(NUM_REGS*DATA_W){1'b0}};
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= {ADDR_W{1'b0}};
      r_frame_err <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ncs_fall) begin
            r_state    <= S_CMD;
            r_cnt      <= {CNT_W{1'b0}};
            r_shift_in <= {FRAME{1'b0}};
            r_out      <= {DATA_W{1'b0}};
            r_cipo     <= 1'b0;
            r_cipo_oe  <= 1'b1;
          end
        end
        S_CMD, S_ADDR, S_DATA, S_DONE: begin
          if (w_ncs_rise) begin
            r_state   <= S_IDLE;
            r_cipo    <= 1'b0;
            r_cipo_oe <= 1'b0;
            r_out     <= {DATA_W{1'b0}};
            if (r_cnt == CNT_W'(FRAME)) begin
              if (w_cmt_wr && w_addr_ok) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                  if (w_cmt_addr == ADDR_W'(k)) begin
                    r_regs[k*DATA_W +: DATA_W] <= w_cmt_data;
                  end
                end
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= w_cmt_addr;
              end
            end else if (r_cnt != {CNT_W{1'b0}}) begin
              r_frame_err <= 1'b1;
            end
          end else if (w_sclk_rise) begin
            r_cnt      <= w_cnt_nx;
            r_shift_in <= w_shift_nx;
            case (r_state)
              S_CMD:  r_state <= S_ADDR;
              S_ADDR: begin
                if (w_cnt_nx == CNT_W'(1 + ADDR_W)) begin
                  r_state <= S_DATA;
                  r_out   <= w_rd_data;
                  r_cipo  <= w_rd_data[DATA_W-1];
                end
              end
              S_DATA: begin
                if (w_cnt_nx == CNT_W'(FRAME)) begin
                  r_state <= S_DONE;
                end
              end
              default: r_state <= r_state;
            endcase
          end else if (w_sclk_fall && (r_cnt > CNT_W'(1 + ADDR_W))) begin
            // the fall right after the load keeps the MSB for the first data rise
            r_out  <= w_out_sh;
            r_cipo <= w_out_sh[DATA_W-1];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cipo      = r_cipo;
  assign cipo_oe   = r_cipo_oe;
  assign regs_flat = r_regs;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_regfile.sv
// Bench for spi_regfile: default instance plus a wide-data instance.
// Expected commit/error events go into per-instance queues; monitors pop
// and compare whenever a DUT pulses wr_strobe or frame_err.
module tb_spi_regfile;

  localparam int HALF = 8;

  typedef struct {
    logic [1:0]   kind;   // {frame_err, wr_strobe}
    logic [31:0]  addr;
    logic [191:0] regs;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ncs0 = 1'b1, ncs1 = 1'b1, copi = 1'b0, sclk = 1'b0;

  logic          cipo0, oe0, str0, err0;
  logic [39:0]   regs0;
  logic [6:0]    waddr0;
  logic          cipo1, oe1, str1, err1;
  logic [191:0]  regs1;
  logic [3:0]    waddr1;

  int checks = 0;
  int errors = 0;
  ev_t q0[$];
  ev_t q1[$];
  logic [39:0]  m0 = '0;
  logic [191:0] m1 = '0;
  ev_t e0, e1;
  logic [31:0] rd;

  spi_regfile dut0 (
    .clk(clk), .rst_n(rst_n), .ncs(ncs0), .copi(copi), .sclk(sclk),
    .cipo(cipo0), .cipo_oe(oe0), .regs_flat(regs0), .wr_strobe(str0),
    .wr_addr(waddr0), .frame_err(err0)
  );

  spi_regfile #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(12), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .ncs(ncs1), .copi(copi), .sclk(sclk),
    .cipo(cipo1), .cipo_oe(oe1), .regs_flat(regs1), .wr_strobe(str1),
    .wr_addr(waddr1), .frame_err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin
    if (rst_n && (str0 || err0)) begin
      if (q0.size() == 0) begin
        chk("d0_unexpected_event", {err0, str0}, 2'b00);
      end else begin
        e0 = q0.pop_front();
        chk("d0_event_kind", {err0, str0}, e0.kind);
        if (e0.kind == 2'b01) chk("d0_wr_addr", waddr0, e0.addr);
        chk("d0_regs_flat", regs0, e0.regs);
      end
    end
  end

  // Monitor for the wide instance
  always @(negedge clk) begin
    if (rst_n && (str1 || err1)) begin
      if (q1.size() == 0) begin
        chk("d1_unexpected_event", {err1, str1}, 2'b00);
      end else begin
        e1 = q1.pop_front();
        chk("d1_event_kind", {err1, str1}, e1.kind);
        if (e1.kind == 2'b01) chk("d1_wr_addr", waddr1, e1.addr);
        chk("d1_regs_flat", regs1, e1.regs);
      end
    end
  end

  // Send nbits of a flen-bit frame (zeros beyond flen); optional read capture
  // from bit rd_first on, optional reset assertion after bit rst_at.
  task automatic spi_xfer(input int dut, input int flen, input logic [31:0] fw,
                          input int nbits, input int rd_first, input int rst_at,
                          output logic [31:0] rdv);
    logic c;
    rdv = '0;
    if (dut == 0) ncs0 = 1'b0; else ncs1 = 1'b0;
    clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < flen) ? fw[flen-1-i] : 1'b0;
      clks(HALF);
      c = (dut == 0) ? cipo0 : cipo1;
      sclk = 1'b1;
      if (rd_first >= 0 && i >= rd_first) rdv = {rdv[30:0], c};
      if (rd_first >= 0 && i == 0) chk("cipo_oe_selected", (dut == 0) ? oe0 : oe1, 1'b1);
      if (rd_first >= 0 && i == rd_first - 1) chk("cipo_zero_in_addr", c, 1'b0);
      clks(HALF);
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_regs", regs0, 40'h0);
        chk("rst_async_ctl", {cipo0, oe0, str0, err0, waddr0}, 11'h0);
        sclk = 1'b0;
        ncs0 = 1'b1;
        ncs1 = 1'b1;
        clks(2 * HALF);
        rst_n = 1'b1;
        clks(2 * HALF);
        return;
      end
      sclk = 1'b0;
    end
    clks(HALF);
    if (rd_first >= 0) chk("cipo_zero_after_last", (dut == 0) ? cipo0 : cipo1, 1'b0);
    ncs0 = 1'b1;
    ncs1 = 1'b1;
    clks(2 * HALF);
    if (rd_first >= 0) chk("cipo_oe_deselected", (dut == 0) ? oe0 : oe1, 1'b0);
  endtask

  task automatic push0(input logic [1:0] kind, input logic [31:0] addr);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.regs = {152'h0, m0};
    q0.push_back(e);
  endtask

  task automatic push1(input logic [1:0] kind, input logic [31:0] addr);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.regs = m1;
    q1.push_back(e);
  endtask

  initial begin
    clks(3);
    chk("reset_regs0", regs0, 40'h0);
    chk("reset_ctl0", {cipo0, oe0, str0, err0, waddr0}, 11'h0);
    chk("reset_regs1", regs1, 192'h0);
    rst_n = 1'b1;
    clks(4);

    // write 0xA5 to address 2
    m0[23:16] = 8'hA5;
    push0(2'b01, 32'd2);
    spi_xfer(0, 16, 32'h82A5, 16, -1, -1, rd);

    // write 0x3C to unimplemented address 9: silent
    spi_xfer(0, 16, {16'h0, 1'b1, 7'd9, 8'h3C}, 16, -1, -1, rd);

    // write 0x5A to address 4, read it back
    m0[39:32] = 8'h5A;
    push0(2'b01, 32'd4);
    spi_xfer(0, 16, {16'h0, 1'b1, 7'd4, 8'h5A}, 16, -1, -1, rd);
    spi_xfer(0, 16, {16'h0, 1'b0, 7'd4, 8'h00}, 16, 8, -1, rd);
    chk("read_addr4", rd, 32'h5A);

    // read unimplemented address returns zero
    spi_xfer(0, 16, {16'h0, 1'b0, 7'd9, 8'h00}, 16, 8, -1, rd);
    chk("read_addr9", rd, 32'h00);

    // short (10-bit) and long (18-bit) write frames to address 1
    push0(2'b10, 32'd0);
    spi_xfer(0, 16, {16'h0, 1'b1, 7'd1, 8'h77}, 10, -1, -1, rd);
    push0(2'b10, 32'd0);
    spi_xfer(0, 16, {16'h0, 1'b1, 7'd1, 8'h77}, 18, -1, -1, rd);

    // select with no clocks: silent
    ncs0 = 1'b0;
    clks(2 * HALF);
    ncs0 = 1'b1;
    clks(2 * HALF);

    // reset during bit 12 of a write of 0xFF to address 0
    spi_xfer(0, 16, {16'h0, 1'b1, 7'd0, 8'hFF}, 16, -1, 12, rd);
    m0 = '0;
    chk("regs_after_reset", regs0, 40'h0);
    m0[7:0] = 8'h11;
    push0(2'b01, 32'd0);
    spi_xfer(0, 16, {16'h0, 1'b1, 7'd0, 8'h11}, 16, -1, -1, rd);

    // wide instance: write 0xBEEF to address 11, read it back
    m1[191:176] = 16'hBEEF;
    push1(2'b01, 32'd11);
    spi_xfer(1, 21, {11'h0, 1'b1, 4'd11, 16'hBEEF}, 21, -1, -1, rd);
    spi_xfer(1, 21, {11'h0, 1'b0, 4'd11, 16'h0000}, 21, 5, -1, rd);
    chk("read_wide_addr11", rd, 32'hBEEF);
    chk("wide_regs_final", regs1, m1);
    chk("regs0_final", regs0, {152'h0, m0});

    clks(20);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
